// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction fetch stage. Owns the fetch PC, drives a req/gnt/rvalid
//            imem port and holds fetched words in an in-order IF/ID buffer.
//            Optional FETCH_PERF_CNT_EN adds fetch and bubble counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_stall_D,
  input  logic        i_flush_D,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_inst_D,
  output logic [31:0] o_pc8_D,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_bubble_cnt,
`endif
  output logic        o_valid_D
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      buf_inst_q [BUF_DEPTH];
  logic [31:0]      buf_inst_d [BUF_DEPTH];
  logic [31:0]      buf_pc_q   [BUF_DEPTH];
  logic [31:0]      buf_pc_d   [BUF_DEPTH];

  logic        flush;
  logic        push;
  logic        pop;
  logic [31:0] head_pc;
  logic [31:0] redirect_tgt;

  assign flush        = i_flush_D | i_redirect;
  assign redirect_tgt = i_redirect_pc & 32'hFFFF_FFFC;
  assign head_pc      = buf_pc_q[rd_ptr_q];

  // A flush wins over decode acceptance: the discarded head is not consumed.
  assign push = (state_q == S_WAIT) & i_imem_rvalid & ~flush;
  assign pop  = o_valid_D & ~i_stall_D & ~flush;

  assign o_valid_D   = (count_q != '0);
  assign o_inst_D    = o_valid_D ? buf_inst_q[rd_ptr_q] : 32'h0;
  assign o_pc8_D     = o_valid_D ? (head_pc + 32'd8) : 32'h0;
  assign o_imem_req  = (state_q == S_REQ);
  assign o_imem_addr = fetch_pc_q;

  always_comb begin
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_comb begin
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;
    if (push) begin
      buf_inst_d[wr_ptr_q] = i_imem_rdata;
      buf_pc_d[wr_ptr_q]   = req_pc_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    if ((state_q == S_REQ) && i_imem_gnt) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      req_pc_d   = fetch_pc_q;
    end
    // A plain flush replays from the oldest buffered instruction.
    if (i_redirect) begin
      fetch_pc_d = redirect_tgt;
    end else if (i_flush_D && o_valid_D) begin
      fetch_pc_d = head_pc;
    end
    case (state_q)
      S_IDLE:  if (count_q < DEPTH_C) state_d = S_REQ;
      S_REQ:   if (i_imem_gnt) state_d = flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (i_imem_rvalid) begin
          state_d = (count_d < DEPTH_C) ? S_REQ : S_IDLE;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (i_imem_rvalid) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_inst_q <= buf_inst_d;
    buf_pc_q   <= buf_pc_d;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + 32'(pop);
    bubble_cnt_d = bubble_cnt_q + 32'(~o_valid_D & ~i_stall_D);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign o_fetch_cnt  = fetch_cnt_q;
  assign o_bubble_cnt = bubble_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed and randomized bench for fetch_stage; popped instructions
//            are checked against an instruction-stream reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_stall_D, i_flush_D, i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt, i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_inst_D, o_pc8_D;
  logic        o_valid_D;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] o_fetch_cnt, o_bubble_cnt;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .i_stall_D(i_stall_D), .i_flush_D(i_flush_D),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_inst_D(o_inst_D), .o_pc8_D(o_pc8_D),
`ifdef FETCH_PERF_CNT_EN
    .o_fetch_cnt(o_fetch_cnt), .o_bubble_cnt(o_bubble_cnt),
`endif
    .o_valid_D(o_valid_D)
  );

  int checks = 0;
  int errors = 0;

  // Memory model and instruction-stream model state
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_wait;
  int          resp_delay;
  int          gnt_block;
  bit          rand_mode;
  logic [31:0] exp_pc;
  int          pops = 0;
  bit          chk_empty, chk_hold, chk_retarget;
  logic [31:0] hold_addr, retarget_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hE3A01005;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    check(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_stall_D = 1'b0; i_flush_D = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0;
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0;
    mem_pend = 1'b0; mem_wait = 0; mem_addr = 32'h0;
    chk_empty = 1'b0; chk_hold = 1'b0; chk_retarget = 1'b0;
    exp_pc = 32'h0; rand_mode = 1'b0; resp_delay = 1; gnt_block = 0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_req", o_imem_req, 1'b0);
    check("rst_addr", o_imem_addr, 32'h0);
    chk1("rst_valid", o_valid_D, 1'b0);
    check("rst_inst", o_inst_D, 32'h0);
    check("rst_pc8", o_pc8_D, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_fetch_cnt", o_fetch_cnt, 32'h0);
    check("rst_bubble_cnt", o_bubble_cnt, 32'h0);
`endif
    reset = 1'b0;
  endtask

  // One clock cycle: protocol checks, memory response, model update, advance.
  task automatic step(input bit stall, input bit flush, input bit redir, input logic [31:0] rpc);
    bit          g, rv, pop;
    logic [31:0] tgt;
    tgt = rpc & 32'hFFFF_FFFC;
    if (chk_empty) chk1("flush_empties", o_valid_D, 1'b0);
    if (chk_hold) begin
      chk1("req_held", o_imem_req, 1'b1);
      check("addr_held", o_imem_addr, hold_addr);
    end
    if (chk_retarget) begin
      chk1("retarget_req", o_imem_req, 1'b1);
      check("retarget_addr", o_imem_addr, retarget_addr);
    end
    if (o_imem_req) begin
      chk1("one_outstanding", mem_pend, 1'b0);
      check("addr_aligned", {30'b0, o_imem_addr[1:0]}, 32'h0);
    end
    g = o_imem_req && (gnt_block == 0) && !(flush && !redir);
    if (rand_mode && ($urandom_range(0, 9) < 3)) g = 1'b0;
    if (o_imem_req && gnt_block > 0) gnt_block--;
    rv = mem_pend && (mem_wait == 0);

    i_stall_D     = stall;
    i_flush_D     = flush;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    i_imem_gnt    = g;
    i_imem_rvalid = rv;
    i_imem_rdata  = rv ? memf(mem_addr) : $urandom;

    pop = o_valid_D && !stall && !flush && !redir;
    if (pop) begin
      check("pop_inst", o_inst_D, memf(exp_pc));
      check("pop_pc8", o_pc8_D, exp_pc + 32'd8);
      exp_pc += 32'd4;
      pops++;
    end
    if (redir) exp_pc = tgt;

    chk_empty     = flush || redir;
    chk_hold      = o_imem_req && !g && !flush && !redir;
    hold_addr     = o_imem_addr;
    chk_retarget  = o_imem_req && !g && (flush || redir);
    retarget_addr = exp_pc;

    if (rv) mem_pend = 1'b0;
    else if (mem_pend && mem_wait > 0) mem_wait--;
    if (g) begin
      mem_pend = 1'b1;
      mem_addr = o_imem_addr;
      if (rand_mode) mem_wait = int'($urandom_range(1, 3)) - 1;
      else           mem_wait = resp_delay - 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    int n;
    bit st, fl, rd;
    int r;

    // Startup latency, fill under stall, redirect while waiting on 0x8
    do_reset();
    chk1("c0_req", o_imem_req, 1'b0);
    step(1, 0, 0, 0);
    chk1("c1_req", o_imem_req, 1'b1);
    check("c1_addr", o_imem_addr, 32'h0);
    step(1, 0, 0, 0);
    chk1("c2_valid", o_valid_D, 1'b0);
    step(1, 0, 0, 0);
    chk1("c3_valid", o_valid_D, 1'b1);
    check("c3_inst", o_inst_D, 32'hE3A01005);
    check("c3_pc8", o_pc8_D, 32'h8);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk1("full_req_c5", o_imem_req, 1'b0);
    step(1, 0, 0, 0);
    chk1("full_req_c6", o_imem_req, 1'b0);
    chk1("full_valid", o_valid_D, 1'b1);
    check("full_head_pc8", o_pc8_D, 32'h8);
    step(0, 0, 0, 0);
    chk1("second_valid", o_valid_D, 1'b1);
    check("second_pc8", o_pc8_D, 32'hC);
    chk1("no_req_before_space", o_imem_req, 1'b0);
    resp_delay = 2;
    step(1, 0, 0, 0);
    chk1("req8", o_imem_req, 1'b1);
    check("req8_addr", o_imem_addr, 32'h8);
    step(1, 0, 0, 0);
    resp_delay = 1;
    step(1, 0, 1, 32'h0000_0102);
    chk1("drain_valid", o_valid_D, 1'b0);
    chk1("drain_req", o_imem_req, 1'b0);
    step(0, 0, 0, 0);
    chk1("redir_req", o_imem_req, 1'b1);
    check("redir_addr", o_imem_addr, 32'h100);
    chk1("redir_valid_c11", o_valid_D, 1'b0);
    step(0, 0, 0, 0);
    chk1("redir_valid_c12", o_valid_D, 1'b0);
    step(0, 0, 0, 0);
    chk1("redir_valid_c13", o_valid_D, 1'b1);
    check("redir_pc8", o_pc8_D, 32'h108);
    check("redir_inst", o_inst_D, memf(32'h100));
    step(0, 0, 0, 0);

    // Grant withheld at 0x4, then flush coinciding with a response
    do_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    gnt_block = 4;
    for (int i = 0; i < 5; i++) begin
      chk1("hold_req", o_imem_req, 1'b1);
      check("hold_addr4", o_imem_addr, 32'h4);
      step(0, 0, 0, 0);
    end
    step(0, 0, 0, 0);
    chk1("after_gnt_req", o_imem_req, 1'b1);
    check("after_gnt_addr", o_imem_addr, 32'h8);
    check("head4_pc8", o_pc8_D, 32'hC);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk1("refetch_req", o_imem_req, 1'b1);
    check("refetch_addr", o_imem_addr, 32'h4);
    p0 = pops;
    n = 0;
    while (pops == p0 && n < 10) begin
      step(0, 0, 0, 0);
      n++;
    end
    check("refetch_pop", pops - p0, 1);

`ifdef FETCH_PERF_CNT_EN
    // Straight-line run: first pop at cycle 3, then one every 2 cycles
    do_reset();
    p0 = pops;
    repeat (22) step(0, 0, 0, 0);
    check("perf_pops", pops - p0, 10);
    check("perf_fetch_cnt", o_fetch_cnt, 32'd10);
    check("perf_bubble_cnt", o_bubble_cnt, 32'd12);
`endif

    // Randomized stalls, flushes, redirects and memory timing
    do_reset();
    rand_mode = 1'b1;
    p0 = pops;
    for (int c = 0; c < 1500; c++) begin
      st = ($urandom_range(0, 9) < 3);
      r  = int'($urandom_range(0, 99));
      rd = (r < 3);
      fl = (r >= 3) && (r < 6) && !mem_pend;
      step(st, fl, rd, $urandom_range(0, 4095));
    end
    chk1("random_progress", (pops - p0) >= 50, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
